// File: rtl/rv32_mod_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single external memory bus.
// Data wins by default; a streak limit guarantees instruction fetches make progress.
module rv32_mod_mem_arbiter #(
  parameter int TIMEOUT     = 255,
  parameter int DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_do,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_di,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_do,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_di,
  output logic        grant_d,
  output logic        busy
);

  localparam logic [3:0]  STREAK_MAX = 4'(DATA_STREAK);
  localparam logic [15:0] TMO_CNT    = 16'(TIMEOUT);
  localparam bit          TMO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_streak;
  logic [15:0] r_cyc;
  logic        w_rsp;
  logic        w_tmo;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_own_i;
  logic        w_own_d;

  assign w_rsp   = mem_ack | mem_err;
  assign w_own_i = (r_state == BUSY_I);
  assign w_own_d = (r_state == BUSY_D);

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      IDLE: begin
        // Instruction side wins only when data is absent or has used its streak.
        if (i_req && (!d_req || (r_streak == STREAK_MAX))) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end else if (d_req) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        w_tmo = TMO_EN && (r_cyc == TMO_CNT) && !w_rsp;
        if (w_rsp || w_tmo) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_streak <= 4'd0;
      r_cyc    <= 16'd0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_be   <= 4'd0;
      mem_addr <= 32'd0;
      mem_do   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) begin
        mem_req  <= 1'b1;
        mem_wr   <= 1'b0;
        mem_be   <= 4'hf;
        mem_addr <= i_addr;
        mem_do   <= 32'd0;
        r_streak <= 4'd0;
        r_cyc    <= 16'd0;
      end else if (w_grant_d) begin
        mem_req  <= 1'b1;
        mem_wr   <= d_wr;
        mem_be   <= d_be;
        mem_addr <= d_addr;
        mem_do   <= d_do;
        r_cyc    <= 16'd0;
        if (i_req) r_streak <= r_streak + 4'd1;
      end else if (r_state != IDLE) begin
        r_cyc <= r_cyc + 16'd1;
        if (w_next == IDLE) mem_req <= 1'b0;
      end
    end
  end

  // Error dominates when the bus flags ack and err together.
  assign i_ack  = w_own_i & mem_ack & ~mem_err;
  assign i_err  = w_own_i & (mem_err | w_tmo);
  assign d_ack  = w_own_d & mem_ack & ~mem_err;
  assign d_err  = w_own_d & (mem_err | w_tmo);
  assign i_data = i_ack ? mem_di : 32'd0;
  assign d_di   = d_ack ? mem_di : 32'd0;

  assign busy    = (r_state != IDLE);
  assign grant_d = w_own_d;

endmodule

// File: doc/rv32_mod_mem_arbiter.md
RV32_MOD_MEM_ARBITER -- requirements
Module: rv32_mod_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles without ack/err before forced error; 0 disables.
REQ-002 SHALL have parameter DATA_STREAK, default 4: max consecutive data grants while instruction port waits; range 1..15.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  1  instruction fetch request, level, held until i_ack/i_err.
REQ-006 i_addr  input  32  fetch address, word-aligned, stable while i_req.
REQ-007 i_ack  output  1  fetch complete, one-cycle pulse.
REQ-008 i_err  output  1  fetch failed, one-cycle pulse.
REQ-009 i_data  output  32  fetch data, valid when i_ack.
REQ-010 d_req  input  1  load/store request, level, held until d_ack/d_err.
REQ-011 d_wr  input  1  1 = store.
REQ-012 d_be  input  4  byte enables.
REQ-013 d_addr  input  32  word-aligned address.
REQ-014 d_do  input  32  store data.
REQ-015 d_ack  output  1  data transfer complete, one-cycle pulse.
REQ-016 d_err  output  1  data transfer failed, one-cycle pulse.
REQ-017 d_di  output  32  load data, valid when d_ack.
REQ-018 mem_req, mem_wr (1), mem_be (4), mem_addr (32), mem_do (32)  output  external bus request, all registered.
REQ-019 mem_ack, mem_err (1), mem_di (32)  input  external bus response; ack/err single-cycle.
REQ-020 grant_d  output  1  1 = data port owns bus (valid while busy).
REQ-021 busy  output  1  transaction outstanding.

Function
REQ-022 FSM states SHALL be IDLE, BUSY_I, BUSY_D.
REQ-023 IDLE with d_req SHALL go to BUSY_D, with only i_req to BUSY_I, unless streak rule (REQ-024) applies.
REQ-024 A 4-bit streak counter SHALL increment on each BUSY_D grant while i_req high, clear on any BUSY_I grant; when counter == DATA_STREAK and both request, instruction SHALL win.
REQ-025 On entering BUSY_x, mem_* SHALL be loaded from the winning port next edge (1-cycle request latency); instruction grants drive mem_wr=0, mem_be=4'b1111, mem_do=0.
REQ-026 mem_* SHALL hold stable for the whole BUSY state; input changes by the owner are ignored.
REQ-027 In BUSY_x, mem_ack or mem_err SHALL be forwarded combinationally to owner's ack/err, mem_di to owner's data, same cycle; non-owner ack/err SHALL be 0.
REQ-028 mem_ack and mem_err together SHALL be treated as err only.
REQ-029 On response cycle, FSM SHALL return to IDLE and mem_req SHALL be 0 from next edge; requester drops req the cycle after ack; no back-to-back grant without an IDLE cycle.
REQ-030 A 16-bit cycle counter SHALL clear on BUSY entry and increment each BUSY cycle; when it reaches TIMEOUT (TIMEOUT≠0) without response, owner err SHALL pulse, FSM returns to IDLE, mem_req drops.
REQ-031 Late mem_ack/mem_err arriving in IDLE SHALL be discarded (no ack/err to either port).
REQ-032 i_data/d_di SHALL equal mem_di whenever respective ack is high; otherwise don't-care.
REQ-033 busy = state≠IDLE; grant_d = state==BUSY_D.

Reset
REQ-034 Reset SHALL force IDLE, mem_req=0, mem_wr=0, mem_be=0, mem_addr=0, mem_do=0, streak=0, cycle counter=0; i_ack/i_err/d_ack/d_err=0.
REQ-035 Reset mid-transaction SHALL abandon it; no ack/err generated.

Verification
REQ-036 i_req, i_addr=0x100, mem_ack 3 cycles later -> mem_req=1 next edge, mem_addr=0x100, mem_be=1111, i_ack pulse with i_data=mem_di, mem_req low next edge.
REQ-037 i_req and d_req same cycle, d_wr=1, d_be=0011, d_addr=0x2000 -> data first (mem_wr=1, mem_be=0011), then instruction granted after one IDLE cycle.
REQ-038 d_req held continuously, i_req pending, DATA_STREAK=4 -> 4 data grants then one instruction grant, streak resets.
REQ-039 TIMEOUT=8, no mem_ack -> d_err pulse 8 cycles after grant, mem_req low next edge; later mem_ack in IDLE ignored.
REQ-040 mem_ack and mem_err same cycle -> owner err=1, ack=0.
REQ-041 reset asserted during BUSY_D -> all outputs zero immediately, no d_ack/d_err, IDLE after release.
